// File: rtl/store_write_queue.sv
// store_write_queue
//   Buffered store path between the execute stage and the memory/MMIO write
//   ports. Store requests are formatted into word-lane beats at enqueue time
//   and held in a DEPTH-entry FIFO, then drained one beat per handshake.
//
//   Optional feature macro: MISALIGNED_SPLIT_EN
//     defined   : misaligned SH/SW to dmem/imem is split into two beats
//     undefined : such requests are dropped with store_err
//
//   Ports
//     clk, rst_n                  clock, async active-low reset
//     req_valid/req_ready         request handshake (req_ready = !full)
//     req_funct3/addr/data        SB/SH/SW, byte address, right-justified data
//     wr_valid/wr_ready           write beat handshake
//     wr_addr/wr_data/wr_mask     beat address, lane data, byte enables
//     wr_dmem/imem/mmio/fb        region selects
//     count                       occupied FIFO entries
//     store_err                   one-cycle pulse after a dropped request
//
//   Output FSM (split build only)
//     state     | meaning
//     ST_FIRST  | presenting beat 0 of the head entry
//     ST_SECOND | presenting beat 1 of a split head entry
module store_write_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_funct3,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [31:0]                  req_data,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [31:0]                  wr_data,
  output logic [3:0]                   wr_mask,
  output logic                         wr_dmem,
  output logic                         wr_imem,
  output logic                         wr_mmio,
  output logic                         wr_fb,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         store_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // sel bit order: {fb, mmio, imem, dmem}
  typedef struct packed {
    logic [ADDR_W-1:0] addr0;
    logic [31:0]       data0;
    logic [3:0]        mask0;
    logic [3:0]        sel;
`ifdef MISALIGNED_SPLIT_EN
    logic              split;
    logic [31:0]       data1;
    logic [3:0]        mask1;
`endif
  } entry_t;

  entry_t            fifo_mem [DEPTH];
  entry_t            head;
  entry_t            fmt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  logic [1:0]        k;
  logic [3:0]        region;
  logic              is_dmem, is_imem, is_mmio, is_fb, is_mem;
  logic              f_ok, misalign;
  logic [3:0]        base;
  logic [31:0]       datum;
  logic [7:0]        mask_wide;
  logic [63:0]       data_wide;

  // Request formatting: everything a beat needs is computed before enqueue.
  always_comb begin
    k         = req_addr[1:0];
    region    = req_addr[ADDR_W-1 -: 4];
    is_dmem   = (region == 4'b0001) || (region == 4'b0011);
    is_imem   = (region == 4'b0010) || (region == 4'b0011);
    is_mmio   = (region == 4'b1000);
    is_fb     = (region == 4'b1001);
    is_mem    = is_dmem || is_imem;
    f_ok      = 1'b1;
    base      = 4'b0000;
    datum     = 32'h0;
    case (req_funct3)
      3'b000:  begin base = 4'b0001; datum = {24'h0, req_data[7:0]};  end
      3'b001:  begin base = 4'b0011; datum = {16'h0, req_data[15:0]}; end
      3'b010:  begin base = 4'b1111; datum = req_data;                end
      default: f_ok = 1'b0;
    endcase
    misalign  = ((req_funct3 == 3'b001) && (k == 2'd3)) ||
                ((req_funct3 == 3'b010) && (k != 2'd0));
    // Double-width shifts: low half is beat 0, high half spills into beat 1.
    mask_wide = {4'b0000, base} << k;
    data_wide = {32'h0, req_data} << {k, 3'b000};

    fmt       = '0;
    fmt.sel   = {is_fb, is_mmio, is_imem, is_dmem};
    fmt.addr0 = {req_addr[ADDR_W-1:2], 2'b00};
    fmt.data0 = datum << {k, 3'b000};
    fmt.mask0 = base << k;
    if (is_mmio) begin
      fmt.addr0 = req_addr;
    end else if (is_fb && (req_funct3 == 3'b000)) begin
      fmt.addr0 = req_addr;
      fmt.data0 = {24'h0, req_data[7:0]};
      fmt.mask0 = 4'b0001;
    end else if (!is_mem && !is_fb) begin
      fmt.mask0 = 4'b0000;
    end

`ifdef MISALIGNED_SPLIT_EN
    if (is_mem && misalign) begin
      fmt.split = 1'b1;
      fmt.data0 = data_wide[31:0];
      fmt.mask0 = mask_wide[3:0];
      fmt.data1 = data_wide[63:32];
      fmt.mask1 = mask_wide[7:4];
    end
    drop = !f_ok || (misalign && !is_mem);
`else
    drop = !f_ok || misalign;
`endif
  end

  assign full      = (count == CNT_W'(DEPTH));
  assign req_ready = !full;
  assign push      = req_valid && req_ready && !drop;
  assign head      = fifo_mem[rd_ptr];

`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic {ST_FIRST, ST_SECOND} state_t;
  state_t state;

  assign pop = wr_valid && wr_ready && ((state == ST_SECOND) || !head.split);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FIRST;
    end else begin
      case (state)
        ST_FIRST:  if (wr_valid && wr_ready && head.split) state <= ST_SECOND;
        ST_SECOND: if (wr_valid && wr_ready)               state <= ST_FIRST;
        default:   state <= ST_FIRST;
      endcase
    end
  end
`else
  assign pop = wr_valid && wr_ready;
`endif

  // Beat fields come straight from the head entry flops; zeroed when empty.
  always_comb begin
    wr_valid = (count != '0);
    wr_addr  = '0;
    wr_data  = '0;
    wr_mask  = '0;
    wr_dmem  = 1'b0;
    wr_imem  = 1'b0;
    wr_mmio  = 1'b0;
    wr_fb    = 1'b0;
    if (wr_valid) begin
      wr_addr = head.addr0;
      wr_data = head.data0;
      wr_mask = head.mask0;
      {wr_fb, wr_mmio, wr_imem, wr_dmem} = head.sel;
`ifdef MISALIGNED_SPLIT_EN
      if (state == ST_SECOND) begin
        wr_addr = head.addr0 + ADDR_W'(4);
        wr_data = head.data1;
        wr_mask = head.mask1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= fmt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      store_err <= 1'b0;
    end else begin
      store_err <= req_valid && req_ready && drop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_write_queue.sv
// Directed bench for store_write_queue. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
// Expectations for misaligned memory stores follow MISALIGNED_SPLIT_EN.
module tb_store_write_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_dmem, wr_imem, wr_mmio, wr_fb;
  logic [2:0]  count;
  logic        store_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  store_write_queue #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_data(req_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_dmem(wr_dmem), .wr_imem(wr_imem), .wr_mmio(wr_mmio), .wr_fb(wr_fb),
    .count(count), .store_err(store_err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one request for one cycle (called on a falling edge).
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_addr   = a;
    req_data   = d;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // Wait (bounded) for a beat, check it, then let the rising edge take it.
  // sel order: {fb, mmio, imem, dmem}
  task automatic expect_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] m, input logic [3:0] sel);
    int n = 0;
    while (!wr_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, wr_valid, 1'b1);
    check({tag, "_addr"},  wr_addr,  a);
    check({tag, "_data"},  wr_data,  d);
    check({tag, "_mask"},  wr_mask,  m);
    check({tag, "_sel"},   {wr_fb, wr_mmio, wr_imem, wr_dmem}, sel);
    @(negedge clk);
  endtask

  task automatic expect_drop(input string tag);
    check({tag, "_err"},   store_err, 1'b1);
    check({tag, "_count"}, count,     3'd0);
    check({tag, "_valid"}, wr_valid,  1'b0);
    @(negedge clk);
    check({tag, "_err_once"}, store_err, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_data   = 32'h0;
    wr_ready   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_count",  count,     3'd0);
    check("rst_valid",  wr_valid,  1'b0);
    check("rst_ready",  req_ready, 1'b1);
    check("rst_err",    store_err, 1'b0);
    check("rst_fields", {wr_addr, wr_data}, 64'h0);
    check("rst_mask",   {wr_mask, wr_fb, wr_mmio, wr_imem, wr_dmem}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned SW to dmem, one-cycle latency.
    send(3'b010, 32'h1000_0004, 32'hDEAD_BEEF);
    check("sw_latency", wr_valid, 1'b1);
    check("sw_count1",  count,    3'd1);
    expect_beat("sw", 32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 4'b0001);
    check("sw_count0",  count,    3'd0);

    // SB to frame buffer keeps byte address and lane 0.
    send(3'b000, 32'h9000_0003, 32'h0000_00A5);
    expect_beat("sb_fb", 32'h9000_0003, 32'h0000_00A5, 4'b0001, 4'b1000);

    // SB to dmem lane 2.
    send(3'b000, 32'h1000_0002, 32'h0000_00A5);
    expect_beat("sb_mem", 32'h1000_0000, 32'h00A5_0000, 4'b0100, 4'b0001);

    // SH to mmio at offset 2: full byte address.
    send(3'b001, 32'h8000_0012, 32'h0000_BEEF);
    expect_beat("sh_mmio", 32'h8000_0012, 32'hBEEF_0000, 4'b1100, 4'b0100);

    // Unmapped region: beat issued with no select and mask 0.
    send(3'b010, 32'h5000_0000, 32'h0000_0001);
    expect_beat("unmapped", 32'h5000_0000, 32'h0000_0001, 4'b0000, 4'b0000);

    // Misaligned SW to dmem+imem.
    send(3'b010, 32'h3000_0006, 32'h1122_3344);
`ifdef MISALIGNED_SPLIT_EN
    expect_beat("split_b0", 32'h3000_0004, 32'h3344_0000, 4'b1100, 4'b0011);
    expect_beat("split_b1", 32'h3000_0008, 32'h0000_1122, 4'b0011, 4'b0011);
    check("split_count", count, 3'd0);
`else
    expect_drop("split_off");
`endif

    // Fill the queue while the target stalls.
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'b010, 32'h1000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
    check("full_count", count,     3'd4);
    check("full_ready", req_ready, 1'b0);
    req_valid  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h1000_0040;
    req_data   = 32'hFFFF_FFFF;
    @(negedge clk);
    req_valid  = 1'b0;
    check("full_no_push", count,     3'd4);
    check("full_no_err",  store_err, 1'b0);
    check("stall_hold",   wr_addr,   32'h1000_0000);
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", wr_valid, 1'b1);
      check("drain_addr",  wr_addr,  32'h1000_0000 + 32'(i * 4));
      check("drain_data",  wr_data,  32'hA000_0000 + 32'(i));
      @(negedge clk);
    end
    check("drain_empty", wr_valid, 1'b0);
    check("drain_count", count,    3'd0);

    // Dropped requests.
    send(3'b001, 32'h8000_0003, 32'h0000_1234);
    expect_drop("sh_mmio_mis");
    send(3'b011, 32'h1000_0000, 32'h0000_1234);
    expect_drop("bad_funct3");

    // SH straddling a region boundary.
    send(3'b001, 32'h1FFF_FFFF, 32'h0000_BEEF);
`ifdef MISALIGNED_SPLIT_EN
    expect_beat("sh_wrap_b0", 32'h1FFF_FFFC, 32'hEF00_0000, 4'b1000, 4'b0001);
    expect_beat("sh_wrap_b1", 32'h2000_0000, 32'h0000_00BE, 4'b0001, 4'b0001);
`else
    expect_drop("sh_wrap_off");
`endif

    // Reset with queued work discards everything.
    wr_ready = 1'b0;
    send(3'b010, 32'h1000_0001, 32'h1122_3344);
    send(3'b010, 32'h1000_0010, 32'h5566_7788);
`ifdef MISALIGNED_SPLIT_EN
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    check("mid_split_mask", wr_mask, 4'b0001);
`endif
    rst_n = 1'b0;
    #1;
    check("rst_mid_count", count,    3'd0);
    check("rst_mid_valid", wr_valid, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    send(3'b010, 32'h1000_0020, 32'h0BAD_F00D);
    expect_beat("post_rst", 32'h1000_0020, 32'h0BAD_F00D, 4'b1111, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
